barrel_sweep_ctrl: RTL and testbench
====================================

// Module: barrel_sweep_ctrl
// PURPOSE
//  Upstream command/sequencing stage for the 8-bit barrel rotator.
//  - Accepts one rotate command per valid/ready handshake.
//  - Drives the rotator's data (bs_d) and amount (bs_c), then registers the rotator result (bs_q).
//  - Emits one output beat per rotation, stepping the amount each beat.
//  - A command yields 1..8 beats, which sweeps the rotations without CPU involvement.
//  - Rotator contract: bs_q[i] = bs_d[(i+bs_c) mod 8], i.e. rotate right by bs_c.
// PARAMETERS
//  DATA_W  8  data width; fixed at 8 to match the rotator
//  AMT_W   3  amount/count width; equals log2(DATA_W)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       synchronous, active-low reset
//  in_valid   in   1       command valid
//  in_ready   out  1       command accepted when in_valid & in_ready
//  in_data    in   DATA_W  word to rotate
//  in_start   in   AMT_W   first rotate amount
//  in_step    in   AMT_W   amount increment per beat (mod 8)
//  in_count   in   AMT_W   number of beats minus 1 (0 = 1 beat, 7 = 8 beats)
//  bs_d       out  DATA_W  to rotator d input (registered)
//  bs_c       out  AMT_W   to rotator c input (registered)
//  bs_q       in   DATA_W  from rotator q output (combinational)
//  out_valid  out  1       result beat valid
//  out_ready  in   1       downstream accepts beat
//  out_data   out  DATA_W  registered rotated word
//  out_amt    out  AMT_W   rotate amount used for this beat
//  out_last   out  1       final beat of the command
// BEHAVIOUR
//  Reset (rst_n low at a rising edge):
//  - State -> IDLE; bs_d, bs_c, out_data, out_amt, remaining <= 0.
//  - out_valid and out_last <= 0.
//  - in_ready = (state==IDLE) & rst_n, so it is low while reset is asserted.
//  Reset mid-burst: the burst is aborted and the pending out beat is dropped.
//  FSM, two states:
//  - IDLE: in_ready=1. On accept:
//    - bs_d <= in_data; bs_c <= in_start; step <= in_step; remaining <= in_count.
//    - Next state is RUN.
//  - RUN: in_ready=0. Commands are ignored; in_valid may stay high.
//  Slot-free condition in RUN: free = !out_valid | out_ready.
//  - When free:
//    - out_data <= bs_q; out_amt <= bs_c; out_last <= (remaining==0); out_valid <= 1.
//    - bs_c <= bs_c + step, wrapping mod 8 (3-bit add, carry discarded).
//    - remaining <= remaining - 1.
//    - If remaining==0, go to IDLE.
//  - When not free: all registers hold and no beat is lost or duplicated.
//  out_valid handling:
//  - out_valid clears only when out_ready=1 and no new beat loads that same cycle.
//  - In IDLE, a pending beat holds until out_ready.
//  - A new command may be accepted while that beat is pending; the first RUN beat then waits for free.
//  out_ready with out_valid=0: no effect.
//  Latency and throughput:
//  - Command accepted at edge N -> first beat valid after edge N+1.
//  - With out_ready=1, one beat per cycle.
//  - Gap between commands is 1 cycle (the IDLE accept cycle).
//  Boundaries:
//  - step=0: every beat is the same rotation.
//  - count=7: 8 beats.
//  - start+step*k wraps mod 8.
//  - bs_d is constant for the whole command.
// TESTING
//  T1 reset:
//   - Stimulus: rst_n low 2 cycles with in_valid=1.
//   - Required: in_ready=0, out_valid=0, bs_d=0, bs_c=0; in_ready=1 the cycle after release.
//  T2 single beat:
//   - Stimulus: d=B4, start=1, step=0, count=0, out_ready=1.
//   - Required: one cycle after accept, out_data=5A, out_amt=1, out_last=1; in_ready back to 1.
//  T3 full sweep:
//   - Stimulus: d=01, start=0, step=1, count=7.
//   - Required: 8 consecutive beats 01,80,40,20,10,08,04,02 with amt 0..7; out_last only on the 8th.
//  T4 wrap:
//   - Stimulus: d=B4, start=6, step=3, count=3.
//   - Required: amt 6,1,4,7 with data D2,5A,4B,69; last on 69.
//  T5 backpressure:
//   - Stimulus: T3, with out_ready low for 3 cycles while beat 80 is presented.
//   - Required: out_data=80 and amt=1 held stable; the full sequence completes unchanged.
//  T6 reset mid-burst:
//   - Stimulus: assert rst_n low after beat 3 of T3.
//   - Required: out_valid=0 next cycle; a new command after release runs from its own start.

Source files
------------

// File: rtl/barrel_sweep_ctrl.sv
// Command sequencer for the 8-bit barrel rotator: accepts a rotate command and
// sweeps the rotate amount over 1..8 output beats with valid/ready flow control.
module barrel_sweep_ctrl #(
   parameter int DATA_W = 8,
   parameter int AMT_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [AMT_W-1:0]  in_start,
   input  logic [AMT_W-1:0]  in_step,
   input  logic [AMT_W-1:0]  in_count,
   output logic [DATA_W-1:0] bs_d,
   output logic [AMT_W-1:0]  bs_c,
   input  logic [DATA_W-1:0] bs_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [AMT_W-1:0]  out_amt,
   output logic              out_last
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [AMT_W-1:0] step;
   logic [AMT_W-1:0] remaining;
   logic             accept;
   logic             free;
   logic             load;

   assign in_ready = (state == IDLE) & rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A beat may only load when the output slot is empty or draining this cycle.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      free      = !out_valid | out_ready;
      load      = 1'b0;
      case (state)
         IDLE: begin
            accept = in_valid & rst_n;
            if (accept) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            load = free;
            if (free && (remaining == '0)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bs_d      <= '0;
         bs_c      <= '0;
         step      <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_amt   <= '0;
         out_last  <= 1'b0;
      end else begin
         if (accept) begin
            bs_d      <= in_data;
            bs_c      <= in_start;
            step      <= in_step;
            remaining <= in_count;
         end else if (load) begin
            out_data  <= bs_q;
            out_amt   <= bs_c;
            out_last  <= (remaining == '0);
            bs_c      <= bs_c + step;
            remaining <= remaining - 1'b1;
         end
         // A pending beat survives into IDLE until downstream takes it.
         if (load) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_barrel_sweep_ctrl.sv
// Scoreboard bench for barrel_sweep_ctrl with a behavioural rotator and a
// sweep-level reference model; directed cases followed by random commands.
module tb_barrel_sweep_ctrl;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_start;
   logic [2:0] in_step;
   logic [2:0] in_count;
   logic [7:0] bs_d;
   logic [2:0] bs_c;
   logic [7:0] bs_q;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_amt;
   logic       out_last;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] amt;
      logic       last;
   } beat_t;

   beat_t exp_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    beats_seen = 0;
   logic  ready_mode = 1'b0;
   logic  ready_manual = 1'b1;
   logic  stall_hold = 1'b0;
   beat_t held;

   barrel_sweep_ctrl #(.DATA_W(8), .AMT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_start  (in_start),
      .in_step   (in_step),
      .in_count  (in_count),
      .bs_d      (bs_d),
      .bs_c      (bs_c),
      .bs_q      (bs_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_amt   (out_amt),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural rotator sitting between bs_d/bs_c and bs_q.
   always_comb begin
      logic [15:0] dbl;
      dbl  = {bs_d, bs_d} >> bs_c;
      bs_q = dbl[7:0];
   end

   function automatic logic [7:0] ref_rot(input logic [7:0] d, input int amt);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[i] = d[(i + amt) % 8];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Expected beats are produced from the command fields when the handshake completes.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         for (int k = 0; k <= int'(in_count); k++) begin
            beat_t b;
            b.amt  = 3'((int'(in_start) + int'(in_step) * k) % 8);
            b.data = ref_rot(in_data, int'(b.amt));
            b.last = (k == int'(in_count));
            exp_q.push_back(b);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stall_hold = 1'b0;
      end else begin
         if (stall_hold) begin
            checkOutput("stall_valid", {7'b0, out_valid}, 8'h01);
            checkOutput("stall_data", out_data, held.data);
            checkOutput("stall_amt", {5'b0, out_amt}, {5'b0, held.amt});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               miscompares++;
               vectors++;
               $display("[TB] FAIL unexpected_beat: got data %h amt %0d, expected no beat", out_data, out_amt);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               checkOutput("beat_data", out_data, e.data);
               checkOutput("beat_amt", {5'b0, out_amt}, {5'b0, e.amt});
               checkOutput("beat_last", {7'b0, out_last}, {7'b0, e.last});
            end
            beats_seen++;
         end
         stall_hold = out_valid && !out_ready;
         held.data  = out_data;
         held.amt   = out_amt;
         held.last  = out_last;
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_manual;
      end
   end

   // Caller is positioned just after a rising edge; returns just after the accepting edge.
   task automatic applyStimulus(input logic [7:0] d, input logic [2:0] start,
                                input logic [2:0] stp, input logic [2:0] cnt);
      int waited;
      in_valid = 1'b1;
      in_data  = d;
      in_start = start;
      in_step  = stp;
      in_count = cnt;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         miscompares++;
         vectors++;
         $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while ((exp_q.size() != 0 || out_valid) && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (exp_q.size() != 0 || out_valid) begin
         miscompares++;
         $display("[TB] FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int waited;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      in_start = 3'd2;
      in_step  = 3'd1;
      in_count = 3'd3;

      // Reset held for two cycles with a command waiting.
      @(negedge clk);
      checkOutput("rst_in_ready", {7'b0, in_ready}, 8'h00);
      checkOutput("rst_out_valid", {7'b0, out_valid}, 8'h00);
      checkOutput("rst_bs_d", bs_d, 8'h00);
      checkOutput("rst_bs_c", {5'b0, bs_c}, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("rel_in_ready", {7'b0, in_ready}, 8'h01);
      @(posedge clk);
      #1;

      // Single beat with explicit latency checks.
      applyStimulus(8'hB4, 3'd1, 3'd0, 3'd0);
      @(negedge clk);
      checkOutput("t2_lat_valid", {7'b0, out_valid}, 8'h00);
      @(negedge clk);
      checkOutput("t2_valid", {7'b0, out_valid}, 8'h01);
      checkOutput("t2_data", out_data, 8'h5A);
      checkOutput("t2_amt", {5'b0, out_amt}, 8'h01);
      checkOutput("t2_last", {7'b0, out_last}, 8'h01);
      checkOutput("t2_in_ready", {7'b0, in_ready}, 8'h01);
      drain();

      // Full sweep, one beat per cycle.
      applyStimulus(8'h01, 3'd0, 3'd1, 3'd7);
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("t3_back_to_back", {7'b0, out_valid}, 8'h01);
      end
      drain();

      // Amount wrap.
      applyStimulus(8'hB4, 3'd6, 3'd3, 3'd3);
      drain();

      // Backpressure on the second beat.
      applyStimulus(8'h01, 3'd0, 3'd1, 3'd7);
      waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      #1;
      ready_manual = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("t5_held_data", out_data, 8'h80);
         checkOutput("t5_held_amt", {5'b0, out_amt}, 8'h01);
      end
      @(posedge clk);
      #1;
      ready_manual = 1'b1;
      drain();

      // Reset in the middle of a sweep, then a fresh command.
      base = beats_seen;
      applyStimulus(8'h01, 3'd0, 3'd1, 3'd7);
      waited = 0;
      while (beats_seen < base + 3 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t6_out_valid", {7'b0, out_valid}, 8'h00);
      checkOutput("t6_in_ready", {7'b0, in_ready}, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(8'($urandom), 3'd5, 3'd2, 3'd2);
      drain();

      // Random commands under random downstream stalls.
      ready_mode = 1'b1;
      for (int n = 0; n < 30; n++) begin
         applyStimulus(8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      end
      ready_mode = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
